// File: rtl/ula_execucao.sv
// Execute stage: eight-op ALU with a registered result and write-back port.
// Multiply uses an iterative shift-add unit that retires one multiplier bit per cycle.
module ula_execucao #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  dadoA,
    input  logic [WIDTH-1:0]  dadoB,
    input  logic [ADDR_W-1:0] addDest,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  resultado,
    output logic              wrEn,
    output logic [ADDR_W-1:0] addWr,
    output logic              zero,
    output logic              carry
);

    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t                state_q, state_d;
    logic [2*WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]      mplier_q, mplier_d;
    logic [2*WIDTH-1:0]    acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]     dest_q, dest_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic [ADDR_W-1:0]     addwr_q, addwr_d;
    logic                  zero_q, zero_d;
    logic                  carry_q, carry_d;
    logic                  done_q, done_d;

    logic [WIDTH:0]        alu_wide;
    logic [2*WIDTH-1:0]    acc_sum;

    // Single-cycle ALU; bit WIDTH carries the carry/borrow for add/sub only.
    always_comb begin
        alu_wide = '0;
        case (op)
            OP_ADD:  alu_wide = {1'b0, dadoA} + {1'b0, dadoB};
            OP_SUB:  alu_wide = {1'b0, dadoA} - {1'b0, dadoB};
            OP_AND:  alu_wide = {1'b0, dadoA & dadoB};
            OP_OR:   alu_wide = {1'b0, dadoA | dadoB};
            OP_XOR:  alu_wide = {1'b0, dadoA ^ dadoB};
            OP_NOT:  alu_wide = {1'b0, ~dadoA};
            OP_PASS: alu_wide = {1'b0, dadoB};
            default: alu_wide = '0;
        endcase
    end

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dest_d   = dest_q;
        res_d    = res_q;
        addwr_d  = addwr_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, dadoA};
                        mplier_d = dadoB;
                        acc_d    = '0;
                        cnt_d    = '0;
                        dest_d   = addDest;
                        state_d  = MUL;
                    end else begin
                        res_d   = alu_wide[WIDTH-1:0];
                        carry_d = alu_wide[WIDTH];
                        zero_d  = (alu_wide[WIDTH-1:0] == '0);
                        addwr_d = addDest;
                        done_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Last iteration: retire the product including this edge's partial sum.
                if (cnt_q == LAST) begin
                    res_d   = acc_sum[WIDTH-1:0];
                    carry_d = |acc_sum[2*WIDTH-1:WIDTH];
                    zero_d  = (acc_sum[WIDTH-1:0] == '0);
                    addwr_d = dest_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dest_q   <= '0;
            res_q    <= '0;
            addwr_q  <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dest_q   <= dest_d;
            res_q    <= res_d;
            addwr_q  <= addwr_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == MUL);
    assign done      = done_q;
    assign wrEn      = done_q;
    assign resultado = res_q;
    assign addWr     = addwr_q;
    assign zero      = zero_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_ula_execucao.sv
// Directed bench for ula_execucao: inputs change on falling edges, outputs are checked on falling edges.
module tb_ula_execucao;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [7:0] dadoA;
    logic [7:0] dadoB;
    logic [2:0] addDest;
    logic       busy;
    logic       done;
    logic [7:0] resultado;
    logic       wrEn;
    logic [2:0] addWr;
    logic       zero;
    logic       carry;

    int compared;
    int mismatched;
    int ndone;
    logic [7:0] cap_res;
    logic       cap_carry;
    logic [2:0] cap_addwr;
    logic [7:0] held_res;

    ula_execucao #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dadoA(dadoA), .dadoB(dadoB), .addDest(addDest),
        .busy(busy), .done(done), .resultado(resultado), .wrEn(wrEn),
        .addWr(addWr), .zero(zero), .carry(carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] res, input logic c,
                             input logic z, input logic dn, input logic [2:0] aw, input logic bz);
        check({tag, ".resultado"}, 32'(resultado), 32'(res));
        check({tag, ".carry"},     32'(carry),     32'(c));
        check({tag, ".zero"},      32'(zero),      32'(z));
        check({tag, ".done"},      32'(done),      32'(dn));
        check({tag, ".wrEn"},      32'(wrEn),      32'(dn));
        check({tag, ".addWr"},     32'(addWr),     32'(aw));
        check({tag, ".busy"},      32'(busy),      32'(bz));
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        start   = 1'b1;
        op      = o;
        dadoA   = a;
        dadoB   = b;
        addDest = d;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1; start = 1'b0; op = 3'd0; dadoA = '0; dadoB = '0; addDest = '0;
        #1;
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ADD with carry out
        @(negedge clk); issue(3'b000, 8'hF0, 8'hF1, 3'd3);
        @(negedge clk); check_out("add", 8'hE1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        // SUB with borrow, then SUB to zero, back-to-back
        issue(3'b001, 8'hF1, 8'hF2, 3'd1);
        @(negedge clk); check_out("sub_borrow", 8'hFF, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
        issue(3'b001, 8'hF5, 8'hF5, 3'd2);
        @(negedge clk); check_out("sub_zero", 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0);
        start = 1'b0;
        @(negedge clk); check_out("hold", 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);

        // MUL 0xF0*0xF1 = 0xE1F0; operands scrambled while iterating
        issue(3'b110, 8'hF0, 8'hF1, 3'd7);
        @(negedge clk);
        start = 1'b0; dadoA = 8'h13; dadoB = 8'h77;
        check("mul1.busy0", 32'(busy), 32'd1);
        check("mul1.done0", 32'(done), 32'd0);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("mul1.busy", 32'(busy), 32'd1);
            check("mul1.wrEn", 32'(wrEn), 32'd0);
            check("mul1.res_held", 32'(resultado), 32'h00);
        end
        @(negedge clk); check_out("mul1", 8'hF0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0);

        // MUL 0x0F*0x11 = 0xFF with an ADD start pulsed mid-iteration
        issue(3'b110, 8'h0F, 8'h11, 3'd5);
        held_res = 8'hF0;
        ndone = 0;
        cap_res = '0; cap_carry = 1'b1; cap_addwr = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 3) issue(3'b000, 8'h01, 8'h01, 3'd2);
            if (i == 4) start = 1'b0;
            if (done) begin
                ndone++;
                cap_res = resultado; cap_carry = carry; cap_addwr = addWr;
            end else if (ndone == 0) begin
                check("mul2.res_held", 32'(resultado), 32'(held_res));
            end
        end
        check("mul2.ndone", 32'(ndone), 32'd1);
        check("mul2.res", 32'(cap_res), 32'hFF);
        check("mul2.carry", 32'(cap_carry), 32'd0);
        check("mul2.addWr", 32'(cap_addwr), 32'd5);

        // Five single-cycle ops on consecutive cycles
        @(negedge clk); issue(3'b100, 8'hF3, 8'hF3, 3'd1);
        @(negedge clk); check_out("xor", 8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
        issue(3'b010, 8'hF4, 8'h0F, 3'd2);
        @(negedge clk); check_out("and", 8'h04, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
        issue(3'b011, 8'hA0, 8'h05, 3'd3);
        @(negedge clk); check_out("or", 8'hA5, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        issue(3'b101, 8'hF0, 8'h99, 3'd4);
        @(negedge clk); check_out("not", 8'h0F, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
        issue(3'b111, 8'h11, 8'h5A, 3'd6);
        @(negedge clk); check_out("pass", 8'h5A, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
        start = 1'b0;

        // Reset in the middle of a multiply
        @(negedge clk); issue(3'b110, 8'h33, 8'h07, 3'd6);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_out("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        check_out("rst_held", 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst.wrEn", 32'(wrEn), 32'd0);
        end
        issue(3'b000, 8'h01, 8'h01, 3'd4);
        @(negedge clk); check_out("add_after_rst", 8'h02, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
        start = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
